// File: rtl/axi_lite_ram_bridge.sv
// axi_lite_ram_bridge: AXI4-Lite slave driving a 1-cycle-latency word RAM with byte-strobed writes.
// Optional RAM_BRIDGE_DECERR_EN: addresses beyond the RAM answer SLVERR and never touch the RAM.
module axi_lite_ram_bridge #(
    parameter int ADDR_WIDTH     = 13,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic [ADDR_WIDTH-1:0]     ram_waddr,
    output logic [DATA_WIDTH/8-1:0]   ram_wstrb,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    output logic [ADDR_WIDTH-1:0]     ram_raddr,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);
    localparam int SW = DATA_WIDTH / 8;
    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_CAPT, R_RESP} r_state_t;
    w_state_t r_wstate, w_wstate_nx;
    r_state_t r_rstate, w_rstate_nx;
    logic                  r_aw_held, r_w_held, r_aw_err, r_ar_err;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_ram_waddr, r_ram_raddr;
    logic [DATA_WIDTH-1:0] r_wdata, r_ram_wdata, r_rdata;
    logic [SW-1:0]         r_wstrb, r_ram_wstrb;
    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_aw_oob, w_ar_oob, w_raw, w_aw_err, w_unused;
    logic [ADDR_WIDTH-1:0] w_awaddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [SW-1:0]         w_wstrb;
`ifdef RAM_BRIDGE_DECERR_EN
    assign w_aw_oob = |s_awaddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2];
    assign w_ar_oob = |s_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2];
`else
    assign w_aw_oob = 1'b0;
    assign w_ar_oob = 1'b0;
`endif
    assign w_unused  = ^{s_awaddr, s_araddr};
    assign s_awready = !reset && r_wstate == W_IDLE && !r_aw_held;
    assign s_wready  = !reset && r_wstate == W_IDLE && !r_w_held;
    assign s_arready = !reset && r_rstate == R_IDLE;
    assign s_bvalid  = r_wstate == W_RESP;
    assign s_rvalid  = r_rstate == R_RESP;
    assign s_bresp   = {s_bvalid && r_aw_err, 1'b0};
    assign s_rresp   = {s_rvalid && r_ar_err, 1'b0};
    assign s_rdata   = r_rdata;
    assign ram_waddr = r_ram_waddr;
    assign ram_wstrb = r_ram_wstrb;
    assign ram_wdata = r_ram_wdata;
    assign ram_raddr = r_ram_raddr;
    assign w_aw_hs   = s_awvalid && s_awready;
    assign w_w_hs    = s_wvalid && s_wready;
    assign w_ar_hs   = s_arvalid && s_arready;
    // AW/W may complete in the same cycle as the issue decision, so bypass the holding registers
    assign w_awaddr  = r_aw_held ? r_awaddr : s_awaddr[ADDR_WIDTH+1:2];
    assign w_aw_err  = r_aw_held ? r_aw_err : w_aw_oob;
    assign w_wdata   = r_w_held ? r_wdata : s_wdata;
    assign w_wstrb   = r_w_held ? r_wstrb : s_wstrb;
    assign w_raw     = r_wstate == W_ISSUE && r_ram_waddr == r_ram_raddr;
    always_comb begin
        w_wstate_nx = r_wstate;
        case (r_wstate)
            W_IDLE:  w_wstate_nx = ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) ? W_ISSUE : W_IDLE;
            W_ISSUE: w_wstate_nx = W_RESP;
            W_RESP:  w_wstate_nx = s_bready ? W_IDLE : W_RESP;
            default: w_wstate_nx = W_IDLE;
        endcase
    end
    always_comb begin
        w_rstate_nx = r_rstate;
        case (r_rstate)
            R_IDLE:  w_rstate_nx = w_ar_hs ? R_WAIT : R_IDLE;
            R_WAIT:  w_rstate_nx = w_raw ? R_WAIT : R_CAPT;
            R_CAPT:  w_rstate_nx = R_RESP;
            default: w_rstate_nx = s_rready ? R_IDLE : R_RESP;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wstate    <= W_IDLE;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_aw_err    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_ram_waddr <= '0;
            r_ram_wdata <= '0;
            r_ram_wstrb <= '0;
        end else begin
            r_wstate    <= w_wstate_nx;
            r_ram_wstrb <= '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_awaddr[ADDR_WIDTH+1:2];
                r_aw_err  <= w_aw_oob;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end
            if (r_wstate == W_IDLE && w_wstate_nx == W_ISSUE) begin
                r_ram_waddr <= w_awaddr;
                r_ram_wdata <= w_wdata;
                r_ram_wstrb <= w_aw_err ? '0 : w_wstrb;
            end
            if (s_bvalid && s_bready) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rstate    <= R_IDLE;
            r_ram_raddr <= '0;
            r_ar_err    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rstate <= w_rstate_nx;
            if (w_ar_hs) begin
                r_ram_raddr <= s_araddr[ADDR_WIDTH+1:2];
                r_ar_err    <= w_ar_oob;
            end
            if (r_rstate == R_CAPT) r_rdata <= r_ar_err ? '0 : ram_rdata;
        end
    end
endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// tb_axi_lite_ram_bridge: table-driven write/read vectors plus hand sequences for ordering,
// back-pressure, read-after-write, reset and address aliasing; B/R beats checked from queues.
module tb_axi_lite_ram_bridge;
    localparam int AW = 13;
    logic        clock = 1'b0, reset = 1'b1;
    logic        s_awvalid = 1'b0, s_awready, s_wvalid = 1'b0, s_wready;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
    logic [3:0]  s_wstrb = '0, ram_wstrb;
    logic        s_bvalid, s_bready = 1'b0, s_arvalid = 1'b0, s_arready, s_rvalid, s_rready = 1'b0;
    logic [1:0]  s_bresp, s_rresp;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0] ram_wdata, ram_rdata = '0;
    logic [31:0] mem [2**AW];
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    int checks = 0, failures = 0, wpulses = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[6];

    axi_lite_ram_bridge dut (
        .clock(clock), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .ram_waddr(ram_waddr), .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // read-first RAM: a write and a read of the same word at one edge returns the old word
    always @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            if (ram_wstrb[b]) mem[ram_waddr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ram_wstrb != 4'h0) wpulses++;
        if (s_bvalid && s_bready) begin
            if (bq.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected: got resp %h expected no beat", s_bresp);
            end else check("bresp", {30'd0, s_bresp}, {30'd0, bq.pop_front()});
        end
        if (s_rvalid && s_rready) begin
            if (rq.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected: got data %h expected no beat", s_rdata);
            end else begin
                logic [33:0] e;
                e = rq.pop_front();
                check("rdata", s_rdata, e[31:0]);
                check("rresp", {30'd0, s_rresp}, {30'd0, e[33:32]});
            end
        end
    end

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, bq.size() + rq.size(), 0);
        bq.delete();
        rq.delete();
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp);
        logic aw_ok, w_ok;
        int n;
        n = 0;
        bq.push_back(resp);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        while ((s_awvalid || s_wvalid || bq.size() != 0) && n < 30) begin
            @(negedge clock);
            aw_ok = s_awvalid && s_awready;
            w_ok  = s_wvalid && s_wready;
            @(posedge clock); #1;
            if (aw_ok) s_awvalid = 1'b0;
            if (w_ok) s_wvalid = 1'b0;
            n++;
        end
        check("write_done", {s_awvalid, s_wvalid, bq.size() != 0}, 0);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        bq.delete();
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        logic ar_ok;
        int n;
        n = 0;
        rq.push_back({resp, d});
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        while ((s_arvalid || rq.size() != 0) && n < 30) begin
            @(negedge clock);
            ar_ok = s_arvalid && s_arready;
            @(posedge clock); #1;
            if (ar_ok) s_arvalid = 1'b0;
            n++;
        end
        check("read_done", {s_arvalid, rq.size() != 0}, 0);
        s_arvalid = 1'b0; s_rready = 1'b0;
        rq.delete();
    endtask

    initial begin
        int p, n;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        tv[0] = '{32'h00, 32'hdeadbeef, 4'hf, 32'hdeadbeef};
        tv[1] = '{32'h04, 32'hdeadbeef, 4'h3, 32'h0000beef};
        tv[2] = '{32'h08, 32'hdeadbeef, 4'hc, 32'hdead0000};
        tv[3] = '{32'h0c, 32'hdeadbeef, 4'h1, 32'h000000ef};
        tv[4] = '{32'h12, 32'hdeadbeef, 4'h2, 32'h0000be00};
        tv[5] = '{32'h18, 32'hcafef00d, 4'h0, 32'h00000000};

        repeat (2) @(negedge clock);
        check("rst_readies", {s_awready, s_wready, s_arready}, 0);
        check("rst_valids", {s_bvalid, s_rvalid}, 0);
        check("rst_resps", {s_bresp, s_rresp}, 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_ram_wstrb", ram_wstrb, 0);
        check("rst_ram_addrs", {ram_waddr, ram_raddr}, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("post_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
        @(posedge clock); #1;

        for (int i = 0; i < 6; i++) begin
            p = wpulses;
            axi_write(tv[i].addr, tv[i].data, tv[i].strb, 2'b00);
            check("wstrb_pulses", wpulses - p, {31'd0, tv[i].strb != 4'h0});
            axi_read(tv[i].addr, tv[i].exp, 2'b00);
        end

        // AR-to-R latency with the response held off
        s_araddr = 32'h0; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clock);
        check("lat_arready", s_arready, 1);
        @(posedge clock); #1 s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 10) begin @(negedge clock); n++; end
        check("r_latency", n, 3);
        rq.push_back({2'b00, 32'hdeadbeef});
        @(posedge clock); #1 s_rready = 1'b1;
        wait_empty("lat_drain");
        s_rready = 1'b0;

        // W ahead of AW, then B back-pressure
        s_wdata = 32'ha5a5a5a5; s_wstrb = 4'hf; s_wvalid = 1'b1; s_bready = 1'b0;
        @(negedge clock);
        check("wfirst_wready", s_wready, 1);
        @(posedge clock); #1 s_wvalid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("wfirst_wready_held", s_wready, 0);
        check("wfirst_no_b", s_bvalid, 0);
        p = wpulses;
        @(posedge clock); #1 s_awaddr = 32'h24; s_awvalid = 1'b1;
        @(negedge clock);
        check("wfirst_awready", s_awready, 1);
        @(posedge clock); #1 s_awvalid = 1'b0;
        repeat (2) @(negedge clock);
        check("wfirst_bvalid", s_bvalid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bvalid_held", {s_bvalid, s_bresp}, 3'b100);
        end
        check("wfirst_pulses", wpulses - p, 1);
        bq.push_back(2'b00);
        @(posedge clock); #1 s_bready = 1'b1;
        wait_empty("wfirst_drain");
        s_bready = 1'b0;
        axi_read(32'h24, 32'ha5a5a5a5, 2'b00);

        // write and read of the same word in one cycle
        s_awaddr = 32'h20; s_wdata = 32'h12345678; s_wstrb = 4'hf; s_araddr = 32'h20;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b0;
        bq.push_back(2'b00);
        @(negedge clock);
        check("raw_readies", {s_awready, s_wready, s_arready}, 3'b111);
        @(posedge clock); #1 s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 10) begin @(negedge clock); n++; end
        check("raw_latency", n, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("raw_rdata_stable", s_rdata, 32'h12345678);
        end
        rq.push_back({2'b00, 32'h12345678});
        @(posedge clock); #1 s_rready = 1'b1;
        wait_empty("raw_drain");
        s_rready = 1'b0; s_bready = 1'b0;

        // reset while R is pending and a write is issuing
        s_araddr = 32'h0; s_arvalid = 1'b1;
        @(posedge clock); #1 s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 10) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        s_awaddr = 32'h40; s_wdata = 32'h11112222; s_wstrb = 4'hf; s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(posedge clock); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clock);
        check("issue_wstrb", ram_wstrb, 4'hf);
        check("issue_rvalid", s_rvalid, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_rvalid", s_rvalid, 0);
        check("mid_rst_wstrb", ram_wstrb, 0);
        check("mid_rst_readies", {s_awready, s_arready}, 0);
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rel_readies", {s_awready, s_wready, s_arready}, 3'b111);
        s_bready = 1'b1; s_rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("rel_no_beat", {s_bvalid, s_rvalid}, 0);
        end
        @(posedge clock); #1 s_bready = 1'b0; s_rready = 1'b0;
        axi_read(32'h40, 32'h0, 2'b00);

        // address above the RAM range
        p = wpulses;
`ifdef RAM_BRIDGE_DECERR_EN
        axi_write(32'h00010000, 32'h0badf00d, 4'hf, 2'b10);
        check("oob_pulses", wpulses - p, 0);
        axi_read(32'h00010000, 32'h0, 2'b10);
        axi_read(32'h0, 32'hdeadbeef, 2'b00);
`else
        axi_write(32'h00010000, 32'h0badf00d, 4'hf, 2'b00);
        check("alias_pulses", wpulses - p, 1);
        axi_read(32'h00010000, 32'h0badf00d, 2'b00);
        axi_read(32'h0, 32'h0badf00d, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_lite_ram_bridge.md
Name: axi_lite_ram_bridge

Overview:
AXI4-Lite slave front end that drives the split read/write word-addressed simulation RAM, which has a 1-cycle read latency and byte-strobed writes.
- Converts AXI-Lite AW/W/B and AR/R transactions into RAM port activity: raddr, waddr, wstrb, wdata in; rdata out.
- Sits directly upstream of the RAM, between the core/interconnect and the memory.
- Read and write paths are independent FSMs; each allows one outstanding transaction.

Parameters:
ADDR_WIDTH, 13, RAM word-address width (RAM holds 2^ADDR_WIDTH 32-bit words).
AXI_ADDR_WIDTH, 32, AXI byte-address width.
DATA_WIDTH, 32, data width; fixed at 32, strobe width DATA_WIDTH/8.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-high reset.
s_awvalid / s_awready  in/out  1  write-address handshake.
s_awaddr  in  AXI_ADDR_WIDTH  write byte address.
s_wvalid / s_wready  in/out  1  write-data handshake.
s_wdata  in  32  write data.
s_wstrb  in  4  write byte strobes.
s_bvalid / s_bready  out/in  1  write-response handshake.
s_bresp  out  2  write response.
s_arvalid / s_arready  in/out  1  read-address handshake.
s_araddr  in  AXI_ADDR_WIDTH  read byte address.
s_rvalid / s_rready  out/in  1  read-data handshake.
s_rdata  out  32  read data.
s_rresp  out  2  read response.
ram_waddr  out  ADDR_WIDTH  RAM write word address.
ram_wstrb  out  4  RAM byte strobes; write occurs at the edge where this is non-zero.
ram_wdata  out  32  RAM write data.
ram_raddr  out  ADDR_WIDTH  RAM read word address.
ram_rdata  in  32  RAM read data, valid one cycle after ram_raddr is presented.

Behaviour:
Reset values (async assert, all registers cleared):
- All s_*ready = 0 while reset is high; s_bvalid = s_rvalid = 0; s_bresp = s_rresp = 0; s_rdata = 0.
- ram_waddr = ram_raddr = 0; ram_wstrb = 0; ram_wdata = 0.
- Both FSMs in IDLE.

Address mapping:
- Word address = byte_addr[ADDR_WIDTH+1:2].
- byte_addr[1:0] is ignored; byte selection comes only from strobes.

Write FSM (W_IDLE -> W_ISSUE -> W_RESP):
- W_IDLE: s_awready = !aw_held, s_wready = !w_held.
- AW and W may arrive in either order or in the same cycle; each is latched independently.
- When both are held (or both handshake this cycle), go to W_ISSUE.
- W_ISSUE (exactly 1 cycle): registered outputs ram_waddr, ram_wdata, ram_wstrb = latched values. ram_wstrb returns to 0 the following cycle.
- W_RESP: s_bvalid = 1, s_bresp = OKAY (2'b00), held until s_bready. On handshake, clear the held flags and return to W_IDLE.
- Latency: AW+W handshake in cycle 0 -> RAM write strobe in cycle 1 -> s_bvalid in cycle 2.
- s_wstrb = 0 is legal: RAM sees no write, response is still OKAY.

Read FSM (R_IDLE -> R_WAIT -> R_CAPT -> R_RESP):
- R_IDLE: s_arready = 1. On handshake, register ram_raddr and go to R_WAIT.
- R_WAIT: 1 cycle, covers RAM latency.
- R_CAPT: s_rdata <= ram_rdata; go to R_RESP.
- R_RESP: s_rvalid = 1, s_rresp = OKAY; s_rdata stable while s_rready = 0. On handshake, go to R_IDLE.
- ram_raddr holds its last value when idle.
- Latency: AR handshake in cycle 0 -> s_rvalid in cycle 3.

Read-after-write hazard:
- If the read FSM would enter R_WAIT in the same cycle the write FSM is in W_ISSUE to the same word, R_WAIT is extended by 1 cycle.
- The read therefore always returns post-write data.

Reset mid-operation:
- All in-flight transactions are discarded.
- s_bvalid/s_rvalid drop immediately; ram_wstrb is forced to 0 asynchronously.

Optional Feature:
Macro: RAM_BRIDGE_DECERR_EN.
- Defined: any AXI address with a non-zero bit above ADDR_WIDTH+1 is out of range.
  - Write: ram_wstrb is held at 0 in W_ISSUE; s_bresp = SLVERR (2'b10).
  - Read: s_rdata = 0, s_rresp = SLVERR; RAM timing is unchanged.
- Undefined: upper bits are ignored; addresses alias modulo 2^(ADDR_WIDTH+2); response is always OKAY.

Test Plan:
- Word write 0xdeadbeef, strobe 0xF, addr 0x0, then read 0x0 -> bresp OKAY, rdata 0xdeadbeef; s_rvalid asserted exactly 3 cycles after AR handshake.
- Half/byte strobes into zeroed words, data 0xdeadbeef:
  - strobe 0x3 at 0x4 -> read 0x0000beef.
  - strobe 0xC at 0x8 -> read 0xdead0000.
  - strobe 0x1 at 0xC -> read 0x000000ef.
  - strobe 0x2 at 0x12 -> read 0x0000be00 (addr[1:0] ignored).
- W before AW (W valid 3 cycles earlier), then s_bready held low 5 cycles -> single ram_wstrb pulse; s_bvalid stays high with OKAY until s_bready.
- Write 0x12345678 to 0x20 with a simultaneous AR to 0x20 -> RAW stall engages; rdata 0x12345678. With s_rready low 4 cycles, rdata stays stable.
- Assert reset while s_rvalid = 1 and during W_ISSUE -> s_rvalid and ram_wstrb drop in the same cycle; after release, s_arready = s_awready = 1 and no B/R beat appears.
- Address 0x00010000 (bit 16 set): with RAM_BRIDGE_DECERR_EN -> bresp/rresp 0b10, no RAM write, rdata 0; without it -> aliases to word 0, OKAY.
